// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: 2-stage FP normaliser (carry right-shift / leading-zero left-normalise) with valid/ready, flush, event counters.
// Optional NORM_STICKY_EN: OR the bit shifted out in the carry case into the result LSB.
module fp_norm_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 28,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_aos,
  input  logic              i_carry,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W-1:0] i_mant,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-1:0] o_mant,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic [CNT_W-1:0]  o_ovf_cnt,
  output logic [CNT_W-1:0]  o_unf_cnt
);
  localparam int LZ_W = $clog2(MANT_W + 1);
  localparam int XW   = EXP_W + LZ_W;
  logic              r1_valid, r1_aos, r1_carry;
  logic [EXP_W-1:0]  r1_exp;
  logic [MANT_W-1:0] r1_mant;
  logic [LZ_W-1:0]   r1_lz;
  logic              r2_valid, r2_ovf, r2_unf;
  logic [EXP_W-1:0]  r2_exp;
  logic [MANT_W-1:0] r2_mant;
  logic [CNT_W-1:0]  r_ovf_cnt, r_unf_cnt;
  logic [LZ_W-1:0]   w_lz;
  logic              w_adv1, w_adv2, w_zero, w_ovf, w_unf, w_xfer;
  logic [EXP_W-1:0]  w_exp_c, w_exp_n, w_exp;
  logic [MANT_W-1:0] w_mant_c, w_mant;
  always_comb begin
    w_lz = LZ_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++)
      if (i_mant[i]) w_lz = LZ_W'(MANT_W - 1 - i);
  end
  assign w_adv2  = ~r2_valid | i_ready;
  assign w_adv1  = ~r1_valid | w_adv2;
  assign o_ready = w_adv1 & ~i_flush & ~i_rst;
  assign w_xfer  = r2_valid & i_ready;
  assign w_zero  = ~r1_carry & (r1_aos ? (r1_exp == '0 && r1_mant == '0) : (r1_mant == '0));
  assign w_exp_c = &r1_exp ? r1_exp : r1_exp + EXP_W'(1);
`ifdef NORM_STICKY_EN
  assign w_mant_c = (r1_mant >> 1) | {{MANT_W-1{1'b0}}, r1_mant[0]};
`else
  assign w_mant_c = r1_mant >> 1;
`endif
  // exponent clamps at 0 but the mantissa is still shifted by the full count
  assign w_exp_n = (XW'(r1_exp) > XW'(r1_lz)) ? EXP_W'(XW'(r1_exp) - XW'(r1_lz)) : '0;
  assign w_exp   = r1_carry ? w_exp_c : w_zero ? '0 : w_exp_n;
  assign w_mant  = r1_carry ? w_mant_c : w_zero ? '0 : r1_mant << r1_lz;
  assign w_ovf   = r1_carry & (&w_exp_c);
  assign w_unf   = ~r1_carry & (w_zero | w_exp_n == '0);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r1_valid <= 1'b0;
      r1_aos   <= 1'b0;
      r1_carry <= 1'b0;
      r1_exp   <= '0;
      r1_mant  <= '0;
      r1_lz    <= '0;
      r2_valid <= 1'b0;
      r2_exp   <= '0;
      r2_mant  <= '0;
      r2_ovf   <= 1'b0;
      r2_unf   <= 1'b0;
    end else if (i_flush) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
    end else begin
      if (w_adv1) begin
        r1_valid <= i_valid;
        if (i_valid) begin
          r1_aos   <= i_aos;
          r1_carry <= i_carry;
          r1_exp   <= i_exp;
          r1_mant  <= i_mant;
          r1_lz    <= w_lz;
        end
      end
      if (w_adv2) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r2_exp  <= w_exp;
          r2_mant <= w_mant;
          r2_ovf  <= w_ovf;
          r2_unf  <= w_unf;
        end
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_xfer & r2_ovf & ~&r_ovf_cnt) r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      if (w_xfer & r2_unf & ~&r_unf_cnt) r_unf_cnt <= r_unf_cnt + CNT_W'(1);
    end
  end
  assign o_valid     = r2_valid;
  assign o_exp       = r2_exp;
  assign o_mant      = r2_mant;
  assign o_overflow  = r2_ovf;
  assign o_underflow = r2_unf;
  assign o_ovf_cnt   = r_ovf_cnt;
  assign o_unf_cnt   = r_unf_cnt;
endmodule
